// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response channel bundle between memory stage and dmem_responder
//
// Request channel : req_valid/req_ready handshake carrying we, byte address,
//                   size, signedness and right-aligned store data.
// Response channel: rsp_valid/rsp_ready handshake carrying load data and the
//                   misalignment flag.
// master = memory stage (issues requests, consumes responses)
// slave  = dmem_responder
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_size, req_signed, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with wait states and byte/half/word lanes
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset (RAM contents are not reset)
//   dmem   - dmem_responder_if.slave: request and response handshakes
// Parameters:
//   ADDR_W - word-address width, RAM depth 2**ADDR_W x 32
//   WAIT   - wait states per access, 0..7
// Build option:
//   DMEM_MISALIGN_ERR_EN - when defined, misaligned half/word accesses skip the
//   RAM and return rsp_err = 1; otherwise the address is aligned down and the
//   access is performed normally with rsp_err tied 0.
module dmem_responder #(
   parameter int ADDR_W = 10,
   parameter int WAIT   = 1
) (
   input logic        clk,
   input logic        rst_n,
   dmem_responder_if.slave dmem
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_e;

   localparam logic [2:0] WAIT_CNT = 3'(WAIT);

   state_e              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W+1:0]   addr_q, addr_d;
   logic [1:0]          size_q, size_d;
   logic                sgn_q, sgn_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;

   logic [31:0]         mem [2**ADDR_W];

   logic [ADDR_W-1:0]   word_idx;
   logic                is_half, is_word;
   logic                misalign;
   logic [1:0]          lane;
   logic [3:0]          be;
   logic [31:0]         wd;
   logic [31:0]         rd_word;
   logic [31:0]         byte_shift, half_shift;
   logic [31:0]         load_data;
   logic                mem_wr;
   logic                unused_addr_hi;

   // Address bits above the RAM window are ignored, so the address wraps.
   assign unused_addr_hi = ^dmem.req_addr[31:ADDR_W+2];

   assign word_idx = addr_q[ADDR_W+1:2];
   assign is_half  = (size_q == 2'b01);
   assign is_word  = size_q[1];          // 2'b11 behaves as a word access

`ifdef DMEM_MISALIGN_ERR_EN
   assign misalign = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
   assign lane     = addr_q[1:0];
`else
   assign misalign = 1'b0;
   // Misaligned halves/words are aligned down to their natural boundary.
   assign lane     = is_word ? 2'b00 : (is_half ? {addr_q[1], 1'b0} : addr_q[1:0]);
`endif

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      be = 4'b0000;
      wd = wdata_q;
      if (is_word) begin
         be = 4'b1111;
         wd = wdata_q;
      end else if (is_half) begin
         be = lane[1] ? 4'b1100 : 4'b0011;
         wd = {2{wdata_q[15:0]}};
      end else begin
         be = 4'b0001 << lane;
         wd = {4{wdata_q[7:0]}};
      end
   end

   assign rd_word    = mem[word_idx];
   assign byte_shift = rd_word >> {lane, 3'b000};
   assign half_shift = rd_word >> {lane[1], 4'b0000};

   always_comb begin
      load_data = rd_word;
      if (is_word) begin
         load_data = rd_word;
      end else if (is_half) begin
         load_data = {{16{sgn_q & half_shift[15]}}, half_shift[15:0]};
      end else begin
         load_data = {{24{sgn_q & byte_shift[7]}}, byte_shift[7:0]};
      end
   end

   // The RAM only changes on the ACCESS edge; reset forces IDLE first, so a
   // store interrupted by reset before that edge never lands.
   assign mem_wr = (state_q == ST_ACCESS) && we_q && !misalign;

   always_ff @(posedge clk) begin
      if (mem_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem[word_idx][8*b +: 8] <= wd[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      size_d  = size_q;
      sgn_d   = sgn_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (dmem.req_valid) begin
               we_d    = dmem.req_we;
               addr_d  = dmem.req_addr[ADDR_W+1:0];
               size_d  = dmem.req_size;
               sgn_d   = dmem.req_signed;
               wdata_d = dmem.req_wdata;
               if (WAIT == 0) begin
                  state_d = ST_ACCESS;
                  cnt_d   = 3'd0;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_CNT;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
               state_d = ST_ACCESS;
               cnt_d   = 3'd0;
            end
         end
         ST_ACCESS: begin
            rdata_d = (we_q || misalign) ? 32'h0 : load_data;
            err_d   = misalign;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (dmem.rsp_ready) begin
               state_d = ST_IDLE;
               rdata_d = 32'h0;
               err_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         size_q  <= 2'b00;
         sgn_q   <= 1'b0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign dmem.req_ready = (state_q == ST_IDLE);
   assign dmem.rsp_valid = (state_q == ST_RESP);
   assign dmem.rsp_rdata = rdata_q;
   assign dmem.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (WAIT=1 and WAIT=3 instances)
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n1, rst_n3;
   logic        sel;            // 0 selects the WAIT=1 instance, 1 the WAIT=3 instance
   logic        t_valid, t_we, t_sgn, t_rsp_ready;
   logic [31:0] t_addr, t_wdata;
   logic [1:0]  t_size;

   int checks = 0;
   int errors = 0;
   logic [32:0] sb_q[$];        // {err, rdata}
   logic [32:0] dropped;

   dmem_responder_if if1();
   dmem_responder_if if3();

   assign if1.req_valid  = t_valid & ~sel;
   assign if1.req_we     = t_we;
   assign if1.req_addr   = t_addr;
   assign if1.req_size   = t_size;
   assign if1.req_signed = t_sgn;
   assign if1.req_wdata  = t_wdata;
   assign if1.rsp_ready  = t_rsp_ready;

   assign if3.req_valid  = t_valid & sel;
   assign if3.req_we     = t_we;
   assign if3.req_addr   = t_addr;
   assign if3.req_size   = t_size;
   assign if3.req_signed = t_sgn;
   assign if3.req_wdata  = t_wdata;
   assign if3.rsp_ready  = t_rsp_ready;

   dmem_responder #(.ADDR_W(10), .WAIT(1)) u_dut1 (.clk(clk), .rst_n(rst_n1), .dmem(if1));
   dmem_responder #(.ADDR_W(10), .WAIT(3)) u_dut3 (.clk(clk), .rst_n(rst_n3), .dmem(if3));

   logic        m_req_ready, m_rsp_valid, m_rsp_err;
   logic [31:0] m_rsp_rdata;
   assign m_req_ready = sel ? if3.req_ready : if1.req_ready;
   assign m_rsp_valid = sel ? if3.rsp_valid : if1.rsp_valid;
   assign m_rsp_rdata = sel ? if3.rsp_rdata : if1.rsp_rdata;
   assign m_rsp_err   = sel ? if3.rsp_err   : if1.rsp_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_req_ready"}, 32'(m_req_ready), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(m_rsp_valid), 32'd0);
      chk({tag, "_rdata"},     m_rsp_rdata,      32'h0);
      chk({tag, "_err"},       32'(m_rsp_err),   32'd0);
   endtask

   task automatic issue(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic sgn, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee);
      int n;
      @(negedge clk);
      t_we = we; t_addr = addr; t_size = size; t_sgn = sgn; t_wdata = wd; t_valid = 1'b1;
      sb_q.push_back({ee, er});
      n = 0;
      while (m_req_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_accept"}, 32'(n < 100), 32'd1);
      @(posedge clk);
      #1;
      // Scramble the request bus after the accept: the DUT must use its captured copy.
      t_valid = 1'b0; t_we = ~we; t_addr = ~addr; t_size = ~size; t_sgn = ~sgn; t_wdata = ~wd;
   endtask

   task automatic wait_rsp(input string tag, input int lat);
      int edges;
      logic [32:0] exp;
      edges = 0;
      @(negedge clk);
      while (m_rsp_valid !== 1'b1 && edges < 50) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      chk({tag, "_latency"}, 32'(edges), 32'(lat));
      exp = sb_q.pop_front();
      chk({tag, "_rdata"}, m_rsp_rdata,    exp[31:0]);
      chk({tag, "_err"},   32'(m_rsp_err), 32'(exp[32]));
   endtask

   task automatic complete(input string tag);
      @(posedge clk);
      #1;
      check_idle({tag, "_after"});
   endtask

   task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic sgn, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee);
      issue(tag, we, addr, size, sgn, wd, er, ee);
      wait_rsp(tag, sel ? 4 : 2);
      complete(tag);
   endtask

   initial begin
      sel = 1'b0; t_valid = 1'b0; t_we = 1'b0; t_addr = 32'h0; t_size = 2'b00;
      t_sgn = 1'b0; t_wdata = 32'h0; t_rsp_ready = 1'b1;
      rst_n1 = 1'b0; rst_n3 = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("rst1");
      sel = 1'b1;
      #1;
      check_idle("rst3");
      sel = 1'b0;
      rst_n1 = 1'b1; rst_n3 = 1'b1;

      // WAIT=1 instance
      xfer("st_w40",  1'b1, 32'h40, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0);
      xfer("ld_w40",  1'b0, 32'h40, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0);
      xfer("clr40",   1'b1, 32'h40, 2'b10, 1'b0, 32'h0,        32'h0,        1'b0);
      xfer("st_b41",  1'b1, 32'h41, 2'b00, 1'b0, 32'h12345680, 32'h0,        1'b0);
      xfer("ld_bs41", 1'b0, 32'h41, 2'b00, 1'b1, 32'h0,        32'hFFFFFF80, 1'b0);
      xfer("ld_bu41", 1'b0, 32'h41, 2'b00, 1'b0, 32'h0,        32'h00000080, 1'b0);
      xfer("ld_w40b", 1'b0, 32'h40, 2'b10, 1'b0, 32'h0,        32'h00008000, 1'b0);
      xfer("clr40b",  1'b1, 32'h40, 2'b10, 1'b0, 32'h0,        32'h0,        1'b0);
      xfer("st_h42",  1'b1, 32'h42, 2'b01, 1'b0, 32'hABCD8001, 32'h0,        1'b0);
      xfer("ld_hs42", 1'b0, 32'h42, 2'b01, 1'b1, 32'h0,        32'hFFFF8001, 1'b0);
      xfer("ld_hu40", 1'b0, 32'h40, 2'b01, 1'b0, 32'h0,        32'h00000000, 1'b0);
      xfer("st_w44",  1'b1, 32'h44, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0,        1'b0);
`ifdef DMEM_MISALIGN_ERR_EN
      xfer("st_w45",  1'b1, 32'h45, 2'b10, 1'b0, 32'h12345678, 32'h0,        1'b1);
      xfer("ld_w44",  1'b0, 32'h44, 2'b10, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0);
      xfer("ld_h43",  1'b0, 32'h43, 2'b01, 1'b0, 32'h0,        32'h0,        1'b1);
`else
      xfer("st_w45",  1'b1, 32'h45, 2'b10, 1'b0, 32'h12345678, 32'h0,        1'b0);
      xfer("ld_w44",  1'b0, 32'h44, 2'b10, 1'b0, 32'h0,        32'h12345678, 1'b0);
      xfer("ld_h43",  1'b0, 32'h43, 2'b01, 1'b0, 32'h0,        32'h00008001, 1'b0);
`endif
      xfer("st_w48",  1'b1, 32'h48, 2'b10, 1'b0, 32'h11A2B3C4, 32'h0,        1'b0);
      xfer("ld_bu4b", 1'b0, 32'h4B, 2'b00, 1'b0, 32'h0,        32'h00000011, 1'b0);
      xfer("ld_bs4a", 1'b0, 32'h4A, 2'b00, 1'b1, 32'h0,        32'hFFFFFFA2, 1'b0);
      xfer("ld_hs48", 1'b0, 32'h48, 2'b01, 1'b1, 32'h0,        32'hFFFFB3C4, 1'b0);
      xfer("ld_sz3",  1'b0, 32'h48, 2'b11, 1'b0, 32'h0,        32'h11A2B3C4, 1'b0);
      xfer("ld_wrap", 1'b0, 32'h80001048, 2'b10, 1'b0, 32'h0,  32'h11A2B3C4, 1'b0);

      // Response back-pressure: outputs hold while rsp_ready is low.
      t_rsp_ready = 1'b0;
      issue("stall", 1'b0, 32'h48, 2'b10, 1'b0, 32'h0, 32'h11A2B3C4, 1'b0);
      wait_rsp("stall", 2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", 32'(m_rsp_valid), 32'd1);
         chk("stall_rdata", m_rsp_rdata,      32'h11A2B3C4);
         chk("stall_ready", 32'(m_req_ready), 32'd0);
      end
      t_rsp_ready = 1'b1;
      complete("stall");

      // WAIT=3 instance: store, then a store aborted by reset in WAIT.
      sel = 1'b1;
      xfer("w3_st10", 1'b1, 32'h10, 2'b10, 1'b0, 32'hAAAA5555, 32'h0, 1'b0);
      issue("w3_abort", 1'b1, 32'h10, 2'b10, 1'b0, 32'h5A5A5A5A, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      chk("w3_busy_ready", 32'(m_req_ready), 32'd0);
      rst_n3 = 1'b0;
      #1;
      check_idle("w3_async_rst");
      dropped = sb_q.pop_front();
      @(negedge clk);
      rst_n3 = 1'b1;
      xfer("w3_ld10", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hAAAA5555, 1'b0);

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS pipeline. It serves the load/store requests issued by the memory stage over a valid/ready request channel and a valid/ready response channel. It owns a word-organised data RAM and applies a programmable wait-state count. It performs byte/halfword/word stores with lane enables and returns zero- or sign-extended load data aligned to bit 0.

## Interface
Parameters:
- ADDR_W, 10: word-address width; RAM depth 2^ADDR_W words of 32 bits
- WAIT, 1: wait states per access, legal range 0..7

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; a request transfers on a rising edge where req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; bits [ADDR_W+1:2] select the word, bits [1:0] select the lane; upper bits ignored (address wraps)
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 treated as word
- req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts; a response transfers on an edge where rsp_valid && rsp_ready
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned access (see Configuration)

## Operation
- States: IDLE, WAIT, ACCESS, RESP. req_ready = (state == IDLE).
- IDLE: on accept, capture we/addr/size/signed/wdata into request registers. Go to WAIT with counter = WAIT, or go to ACCESS if WAIT == 0. Later changes on req_* are ignored.
- WAIT: the counter decrements each cycle. Go to ACCESS on the edge where counter == 1.
- ACCESS: single RAM operation on the captured request. Register rsp_rdata/rsp_err and go to RESP.
- RESP: rsp_valid = 1 and outputs held stable until rsp_ready. On the transfer edge, go to IDLE and clear rsp_rdata/rsp_err to 0.
- Store lanes (little-endian):
  - byte writes lane addr[1:0] with wdata[7:0]
  - half writes lanes {2*addr[1]+1, 2*addr[1]} with wdata[15:0]
  - word writes all four lanes
  - unselected lanes are unchanged
- Load extraction:
  - byte = word >> (8*addr[1:0]), bits [7:0]
  - half = word >> (16*addr[1]), bits [15:0]
  - extend to 32 bits per req_signed; word returned unmodified
- Misaligned requests (enabled case): half with addr[0] = 1, word with addr[1:0] != 0. No RAM write, rsp_rdata = 0, rsp_err = 1, same latency as a normal access.
- RAM contents are not affected by reset. Initial contents are undefined.

## Timing
- Reset values: state IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0.
- rsp_valid is first high in the cycle after clock edge number WAIT+1 following the accept edge. For WAIT = 0, it is high in the cycle after the next edge.
- Minimum spacing between accepts is WAIT+3 cycles when rsp_ready is held at 1.
- The store is committed at the ACCESS edge. A load issued after that store's response reads the new data.
- rsp_ready held low stalls indefinitely in RESP. req_ready stays 0 throughout.
- rsp_ready high outside RESP has no effect. req_valid high outside IDLE is not accepted.
- Reset asserted in WAIT/ACCESS/RESP: state goes to IDLE immediately. Any response is dropped. A store not yet past its ACCESS edge is not performed. A store already committed stays in RAM.

## Configuration
- DMEM_MISALIGN_ERR_EN defined: misalignment detection as above, rsp_err driven.
- Not defined: rsp_err tied 0. The half address is aligned down via addr[0] = 0 and the word address via addr[1:0] = 0. The access is then performed normally.

## Test plan
- WAIT=1, rsp_ready=1:
  - Store word 0xDEADBEEF to 0x40, then load word 0x40 -> rdata 0xDEADBEEF, err 0.
  - rsp_valid is high in the cycle after the second edge following each accept.
- Store byte 0x80 to 0x41 over 0x00000000, then load byte signed 0x41 -> 0xFFFFFF80. Load byte unsigned 0x41 -> 0x00000080. Load word 0x40 -> 0x00008000.
- Store half 0x8001 to 0x42, then:
  - load half signed 0x42 -> 0xFFFF8001
  - load half unsigned 0x40 -> 0x00000000 (low half untouched after clearing)
- With DMEM_MISALIGN_ERR_EN, store word 0x12345678 to 0x45 -> err 1, rdata 0. A following load word 0x44 returns the prior contents. Without the macro, the same store writes 0x44.
- Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready 0. Release -> one transfer, then req_ready = 1 the next cycle.
- WAIT=3, pulse rst_n low one cycle after a store accept -> outputs return to reset values asynchronously, and a later load of that address shows the store was not performed.
